// File: rtl/aes128_decrypt_round_ctrl.sv
// Iterative AES-128 decryption sequencer: one inverse round per clock over a 128-bit state register,
// with round keys fetched combinationally from an external key store by index.

module aes_add_round_key (
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   output logic [127:0] state_out
);
   assign state_out = state_in ^ round_key;
endmodule

module aes_inv_shift_rows (
   input  logic [127:0] state_in,
   output logic [127:0] state_out
);
   // Byte (row r, column c) sits at index 4*c+r; row r rotates right by r columns.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign state_out[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
   end
endmodule

module aes_inv_sub_bytes (
   input  logic [127:0] state_in,
   output logic [127:0] state_out
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse affine transform followed by GF(2^8) inversion as x^254 via an addition chain.
   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] b, x2, x3, x12, x15, x240;
      b    = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      x2   = gf_mul(b, b);
      x3   = gf_mul(x2, b);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      return gf_mul(gf_mul(x240, x12), x2);
   endfunction

   for (genvar i = 0; i < 16; i++) begin : g_byte
      assign state_out[127-8*i -: 8] = inv_sbox(state_in[127-8*i -: 8]);
   end
endmodule

module aes_inv_mix_columns (
   input  logic [127:0] state_in,
   output logic [127:0] state_out
);
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] a);
      return xt(xt(xt(a))) ^ a;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] a);
      return xt(xt(xt(a))) ^ xt(a) ^ a;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] a);
      return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] a);
      return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
   endfunction

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = state_in[127-32*c -: 8];
      assign a1 = state_in[119-32*c -: 8];
      assign a2 = state_in[111-32*c -: 8];
      assign a3 = state_in[103-32*c -: 8];
      assign state_out[127-32*c -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
      assign state_out[119-32*c -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
      assign state_out[111-32*c -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
      assign state_out[103-32*c -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
   end
endmodule

module aes128_decrypt_round_ctrl #(
   parameter int ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   output logic [3:0]   key_idx,
   input  logic [127:0] key_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic         busy
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]   fsm_q, fsm_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] state_q, state_d;
   logic [127:0] isr_out, isb_out, ark_in, ark_out, imc_out;

   // One AddRoundKey serves both the initial whitening (from data_in) and every round.
   assign ark_in = (fsm_q == S_IDLE) ? data_in : isb_out;

   aes_inv_shift_rows  u_isr (.state_in(state_q), .state_out(isr_out));
   aes_inv_sub_bytes   u_isb (.state_in(isr_out), .state_out(isb_out));
   aes_add_round_key   u_ark (.state_in(ark_in), .round_key(key_in), .state_out(ark_out));
   aes_inv_mix_columns u_imc (.state_in(ark_out), .state_out(imc_out));

   assign in_ready  = (fsm_q == S_IDLE);
   assign out_valid = (fsm_q == S_DONE);
   assign busy      = (fsm_q != S_IDLE);
   assign data_out  = state_q;

   always_comb begin
      key_idx = 4'd0;
      case (fsm_q)
         S_IDLE:  key_idx = 4'(ROUNDS);
         S_RUN:   key_idx = round_q;
         default: key_idx = 4'd0;
      endcase
   end

   always_comb begin
      fsm_d   = fsm_q;
      round_d = round_q;
      state_d = state_q;
      case (fsm_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = ark_out;
               round_d = 4'(ROUNDS - 1);
               fsm_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (round_q != 4'd0) begin
               state_d = imc_out;
               round_d = round_q - 4'd1;
            end else begin
               state_d = ark_out;
               fsm_d   = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) fsm_d = S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= S_IDLE;
         round_q <= 4'd0;
         state_q <= 128'd0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         state_q <= state_d;
      end
   end
endmodule
